// File: rtl/dm_pipe.sv
// dm_pipe: MEM-stage data memory with sub-word access, LAT-cycle responses and a post-reset clear sweep.
// Optional DM_TRACE_EN: print one trace line per successful store.
module dm_pipe #(
    parameter int DEPTH = 3072,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        busy
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          store_ok;
    logic          is_b;
    logic          is_h;
    logic          sgn;
    logic [1:0]    err;
    logic [CW-1:0] widx;
    logic [31:0]   cur;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld;
    logic [31:0]   wd;
    logic [3:0]    be;
    logic [31:0]   mask;
    logic [31:0]   merged;

    logic [LAT-1:0] vld;
    logic [31:0]    dat [LAT];
    logic [1:0]     ers [LAT];

    assign is_b = (req_mode == 3'd1) || (req_mode == 3'd3);
    assign is_h = (req_mode == 3'd2) || (req_mode == 3'd4);
    assign sgn  = (req_mode == 3'd1) || (req_mode == 3'd2);

    assign resp_valid = vld[LAT-1];
    assign resp_rdata = dat[LAT-1];
    assign resp_err   = ers[LAT-1];
    assign busy       = (state != IDLE);
    assign req_ready  = (state == IDLE) || (state == WAIT && resp_valid);

    assign accept   = req_valid && req_ready && !reset;
    assign store_ok = accept && req_we && (err == 2'b00);

    assign widx     = req_addr[CW+1:2];
    assign cur      = mem[widx];
    assign byte_sel = cur[{req_addr[1:0], 3'b000} +: 8];
    assign half_sel = cur[{req_addr[1], 4'b0000} +: 16];

    // Reserved mode beats misalignment, which beats range.
    always_comb begin
        err = 2'b00;
        if (req_mode > 3'd4)
            err = 2'b11;
        else if ((req_mode == 3'd0 && req_addr[1:0] != 2'b00) ||
                 (is_h && req_addr[0]))
            err = 2'b01;
        else if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))
            err = 2'b10;
    end

    always_comb begin
        ld = cur;
        unique case (1'b1)
            is_b:    ld = {{24{sgn & byte_sel[7]}}, byte_sel};
            is_h:    ld = {{16{sgn & half_sel[15]}}, half_sel};
            default: ld = cur;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        wd = req_wdata;
        unique case (1'b1)
            is_b: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
            end
            is_h: begin
                be = 4'b0011 << {req_addr[1], 1'b0};
                wd = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged = (cur & ~mask) | (wd & mask);

    always_comb begin
        state_n = state;
        unique case (state)
            CLEAR:   if (cnt == CW'(DEPTH - 1)) state_n = IDLE;
            IDLE:    if (accept) state_n = WAIT;
            WAIT:    if (resp_valid && !accept) state_n = IDLE;
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == CLEAR) cnt <= cnt + 1'b1;
        end
    end

    // Storage is not reset: a store survives reset until the sweep reaches it.
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR)
            mem[cnt] <= '0;
        else if (store_ok)
            mem[widx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
                ers[i] <= '0;
            end
        end else begin
            vld[0] <= accept;
            dat[0] <= (accept && !req_we && err == 2'b00) ? ld : '0;
            ers[0] <= accept ? err : 2'b00;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
                ers[i] <= ers[i-1];
            end
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (store_ok)
            $display("%d@%h: *%h <= %h", $time, req_pc,
                     {req_addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_pipe.sv
// tb_dm_pipe: three dm_pipe instances (DEPTH=16; LAT=1,3,4) checked against a
// cycle-level behavioural model plus literal expectations.
module tb_dm_pipe;
    localparam int NI = 3;
    localparam int DP = 16;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          pass = 0;

    logic        rst [NI];
    logic        rv  [NI];
    logic        rr  [NI];
    logic        we  [NI];
    logic [2:0]  md  [NI];
    logic [31:0] ad  [NI];
    logic [31:0] wd  [NI];
    logic [31:0] pc  [NI];
    logic        vv  [NI];
    logic [31:0] rd  [NI];
    logic [1:0]  er  [NI];
    logic        bz  [NI];

    int lat_of [NI] = '{1, 3, 4};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dm_pipe #(
            .DEPTH(DP),
            .LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk(clk),
            .reset(rst[g]),
            .req_valid(rv[g]),
            .req_ready(rr[g]),
            .req_we(we[g]),
            .req_mode(md[g]),
            .req_addr(ad[g]),
            .req_wdata(wd[g]),
            .req_pc(pc[g]),
            .resp_valid(vv[g]),
            .resp_rdata(rd[g]),
            .resp_err(er[g]),
            .busy(bz[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          known [NI];
    int          clr_end [NI];
    bit          pend [NI];
    int          pcy [NI];
    logic [31:0] pdat [NI];
    logic [1:0]  perr [NI];
    logic [31:0] mm [NI][DP];

    function automatic logic [1:0] m_err(input logic [2:0] m, input logic [31:0] a);
        if (m > 3'd4) return 2'd3;
        if ((m == 0 && a % 4 != 0) || ((m == 2 || m == 4) && a % 2 != 0)) return 2'd1;
        if ((a >> 2) >= DP) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] m,
                                           input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (m)
            3'd0: return w;
            3'd1: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd2: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd3: return b;
            3'd4: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] m,
                                            input logic [31:0] a, input logic [31:0] d);
        int p;
        if (m == 1 || m == 3) begin
            p = 8 * (a % 4);
            return (w & ~(32'hFF << p)) | ((d & 32'hFF) << p);
        end
        if (m == 2 || m == 4) begin
            p = 16 * ((a / 2) % 2);
            return (w & ~(32'hFFFF << p)) | ((d & 32'hFFFF) << p);
        end
        return d;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (known[k]) begin
                bit e_rv, e_rdy, e_busy;
                logic [1:0] e;
                int idx;
                e_rv   = pend[k] && pcy[k] == cyc;
                e_rdy  = cyc >= clr_end[k] && (!pend[k] || e_rv);
                e_busy = cyc < clr_end[k] || pend[k];
                chk($sformatf("m%0d_ready", k), rr[k], e_rdy);
                chk($sformatf("m%0d_valid", k), vv[k], e_rv);
                chk($sformatf("m%0d_busy", k), bz[k], e_busy);
                if (e_rv) begin
                    chk($sformatf("m%0d_rdata", k), rd[k], pdat[k]);
                    chk($sformatf("m%0d_err", k), er[k], perr[k]);
                    pend[k] = 1'b0;
                end
                if (rst[k]) begin
                    pend[k] = 1'b0;
                    clr_end[k] = cyc + DP + 1;
                    for (int i = 0; i < DP; i++) mm[k][i] = 32'h0;
                end else if (rv[k] && e_rdy) begin
                    e = m_err(md[k], ad[k]);
                    idx = (ad[k] >> 2) % DP;
                    pdat[k] = 32'h0;
                    if (we[k]) begin
                        if (e == 0) mm[k][idx] = m_store(mm[k][idx], md[k], ad[k], wd[k]);
                    end else if (e == 0) begin
                        pdat[k] = m_load(mm[k][idx], md[k], ad[k]);
                    end
                    perr[k] = e;
                    pend[k] = 1'b1;
                    pcy[k] = cyc + lat_of[k];
                end
            end else if (rst[k]) begin
                known[k] = 1'b1;
                clr_end[k] = cyc + DP + 1;
                for (int i = 0; i < DP; i++) mm[k][i] = 32'h0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int k, input logic w, input logic [2:0] m,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic [1:0] e,
                          output int ac, output int rc);
        bit got;
        r = 32'hX; e = 2'bXX; ac = -1; rc = -1;
        rv[k] = 1'b1; we[k] = w; md[k] = m; ad[k] = a; wd[k] = d; pc[k] = 32'h400 + a;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (rr[k]) begin got = 1'b1; ac = cyc; end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        rv[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (vv[k]) begin got = 1'b1; r = rd[k]; e = er[k]; rc = cyc; end
        end
        if (!got) chk("resp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [1:0] e;
        int ac, rc, nv;
        int acc [3];
        int rcy [3];
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; rv[k] = 1'b0; we[k] = 1'b0; md[k] = 3'd0;
            ad[k] = 32'h0; wd[k] = 32'h0; pc[k] = 32'h0;
        end
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        // Reset state and clear duration
        @(negedge clk);
        chk("rst_ready", rr[0], 0);
        chk("rst_valid", vv[0], 0);
        chk("rst_rdata", rd[0], 0);
        chk("rst_err", er[0], 0);
        chk("rst_busy", bz[0], 1);
        repeat (15) @(negedge clk);
        chk("clear_last_ready", rr[0], 0);
        chk("clear_last_busy", bz[0], 1);
        @(negedge clk);
        chk("idle_ready", rr[0], 1);
        chk("idle_busy", bz[0], 0);
        @(posedge clk); #1;

        do_req(0, 0, 3'd0, 32'h0, 32'h0, r, e, ac, rc);
        chk("t1_rdata", r, 32'h0);
        chk("t1_err", e, 0);
        chk("t1_lat", rc - ac, 1);

        // Store then sub-word loads
        do_req(0, 1, 3'd0, 32'h8, 32'h8899AABB, r, e, ac, rc);
        chk("t2_sw_rdata", r, 32'h0);
        do_req(0, 0, 3'd0, 32'h8, 32'h0, r, e, ac, rc);
        chk("t2_lw", r, 32'h8899AABB);
        do_req(0, 0, 3'd1, 32'hB, 32'h0, r, e, ac, rc);
        chk("t2_lb", r, 32'hFFFFFF88);
        do_req(0, 0, 3'd3, 32'hB, 32'h0, r, e, ac, rc);
        chk("t2_lbu", r, 32'h00000088);
        do_req(0, 0, 3'd2, 32'hA, 32'h0, r, e, ac, rc);
        chk("t2_lh", r, 32'hFFFF8899);
        do_req(0, 0, 3'd4, 32'h8, 32'h0, r, e, ac, rc);
        chk("t2_lhu", r, 32'h0000AABB);

        // Sub-word stores
        do_req(0, 1, 3'd0, 32'h4, 32'h0, r, e, ac, rc);
        do_req(0, 1, 3'd1, 32'h5, 32'h123456CD, r, e, ac, rc);
        do_req(0, 1, 3'd2, 32'h6, 32'hFFFFBEEF, r, e, ac, rc);
        do_req(0, 0, 3'd0, 32'h4, 32'h0, r, e, ac, rc);
        chk("t3_word", r, 32'hBEEFCD00);

        // Errors
        do_req(0, 0, 3'd0, 32'h2, 32'h0, r, e, ac, rc);
        chk("t5_lw_mis_err", e, 1);
        chk("t5_lw_mis_rd", r, 0);
        do_req(0, 0, 3'd2, 32'h41, 32'h0, r, e, ac, rc);
        chk("t5_lh_mis_err", e, 1);
        chk("t5_lh_mis_rd", r, 0);
        do_req(0, 1, 3'd0, 32'h0, 32'h11223344, r, e, ac, rc);
        do_req(0, 1, 3'd0, 32'h40, 32'hDEADBEEF, r, e, ac, rc);
        chk("t5_sw_oor_err", e, 2);
        chk("t5_sw_oor_rd", r, 0);
        do_req(0, 0, 3'd0, 32'h0, 32'h0, r, e, ac, rc);
        chk("t5_mem_kept", r, 32'h11223344);
        do_req(0, 0, 3'd6, 32'h0, 32'h0, r, e, ac, rc);
        chk("t5_mode6_err", e, 3);
        chk("t5_mode6_rd", r, 0);

        // LAT=3 back-to-back loads
        for (int i = 0; i < 3; i++) begin acc[i] = -1; rcy[i] = -1; end
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    bit got;
                    rv[1] = 1'b1; we[1] = 1'b0; md[1] = 3'd0; ad[1] = 32'(i * 4);
                    got = 1'b0;
                    for (int j = 0; j < 32 && !got; j++) begin
                        @(negedge clk);
                        if (rr[1]) begin got = 1'b1; acc[i] = cyc; end
                    end
                    @(posedge clk); #1;
                end
                rv[1] = 1'b0;
            end
            begin
                int n;
                n = 0;
                for (int j = 0; j < 40 && n < 3; j++) begin
                    @(negedge clk);
                    if (vv[1]) begin rcy[n] = cyc; n++; end
                end
            end
        join
        chk("t4_resp1", rcy[0] - acc[0], 3);
        chk("t4_resp2", rcy[1] - acc[0], 6);
        chk("t4_resp3", rcy[2] - acc[0], 9);
        @(posedge clk); #1;

        // LAT=4 reset mid-request
        do_req(2, 1, 3'd0, 32'h0, 32'h55AA55AA, r, e, ac, rc);
        do_req(2, 0, 3'd0, 32'h0, 32'h0, r, e, ac, rc);
        chk("t6_pre", r, 32'h55AA55AA);
        rv[2] = 1'b1; we[2] = 1'b0; md[2] = 3'd0; ad[2] = 32'h0;
        ac = -1;
        for (int j = 0; j < 32 && ac < 0; j++) begin
            @(negedge clk);
            if (rr[2]) ac = cyc;
        end
        if (ac < 0) chk("t6_accept_timeout", 0, 1);
        @(posedge clk); #1;
        rv[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (vv[2]) nv++;
        end
        chk("t6_no_resp", nv, 0);
        chk("t6_ready_back", rr[2], 1);
        @(posedge clk); #1;
        do_req(2, 0, 3'd0, 32'h0, 32'h0, r, e, ac, rc);
        chk("t6_cleared", r, 32'h0);
        chk("t6_lat", rc - ac, 4);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
